mem_lsu: RTL and testbench

MEM_LSU -- requirements
Module: mem_lsu

---
 rtl/mem_lsu.sv | 193 +++++++++++++++++++
 tb/tb_mem_lsu.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_lsu.sv
// Load/store unit for the EX/MEM stage: one entry in flight, 4-state FSM (IDLE/REQ/WAIT/RESP).
// Latency: 1 cycle non-mem/exception, 2+g store, 3+g+r load; o_ready only in IDLE, REQ holds until grant.
module mem_lsu #(
    parameter int TIMEOUT = 16
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_valid,
    output logic        o_ready,
    input  logic [31:0] i_alu_data,
    input  logic [31:0] i_st_data,
    input  logic        i_lsu_rden,
    input  logic        i_lsu_wren,
    input  logic [2:0]  i_funct3,
    input  logic [4:0]  i_rd_addr,
    input  logic        i_flush,
    output logic        o_mem_req,
    output logic        o_mem_we,
    output logic [29:0] o_mem_addr,
    output logic [31:0] o_mem_wdata,
    output logic [3:0]  o_mem_bmask,
    input  logic        i_mem_gnt,
    input  logic        i_mem_rvalid,
    input  logic [31:0] i_mem_rdata,
    output logic        o_wb_valid,
    output logic [31:0] o_wb_data,
    output logic [4:0]  o_wb_rd,
    output logic [1:0]  o_exc
);
    typedef enum logic [1:0] {IDLE, REQ, WAIT, RESP} state_t;
    localparam int CW = $clog2(TIMEOUT + 1);

    state_t        state_q, state_d;
    logic [31:0]   addr_q, addr_d;
    logic [2:0]    f3_q, f3_d;
    logic [4:0]    rd_q, rd_d;
    logic          st_op_q, st_op_d;
    logic [31:0]   wdata_q, wdata_d;
    logic [3:0]    bmask_q, bmask_d;
    logic [31:0]   wb_data_q, wb_data_d;
    logic [1:0]    exc_q, exc_d;
    logic          drop_q, drop_d;
    logic [CW-1:0] cnt_q, cnt_d;

    logic        is_mem, f3_ok, misal;
    logic [31:0] st_lanes, rd_shift, ld_data;
    logic [3:0]  st_mask;

    // Both enables set decodes as a store.
    assign is_mem = i_lsu_rden | i_lsu_wren;
    assign f3_ok  = i_lsu_wren ? (i_funct3 inside {3'b000, 3'b001, 3'b010})
                               : (i_funct3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101});
    assign misal  = ((i_funct3[1:0] == 2'b01) && i_alu_data[0]) ||
                    ((i_funct3[1:0] == 2'b10) && (i_alu_data[1:0] != 2'b00));

    always_comb begin
        st_lanes = i_st_data;
        st_mask  = 4'b1111;
        case (i_funct3[1:0])
            2'b00: begin
                st_lanes = {4{i_st_data[7:0]}};
                st_mask  = 4'b0001 << i_alu_data[1:0];
            end
            2'b01: begin
                st_lanes = {2{i_st_data[15:0]}};
                st_mask  = 4'b0011 << i_alu_data[1:0];
            end
            default: ;
        endcase
    end

    assign rd_shift = i_mem_rdata >> {addr_q[1:0], 3'b000};
    always_comb begin
        ld_data = rd_shift;
        case (f3_q)
            3'b000:  ld_data = {{24{rd_shift[7]}}, rd_shift[7:0]};
            3'b001:  ld_data = {{16{rd_shift[15]}}, rd_shift[15:0]};
            3'b100:  ld_data = {24'd0, rd_shift[7:0]};
            3'b101:  ld_data = {16'd0, rd_shift[15:0]};
            default: ld_data = rd_shift;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        f3_d      = f3_q;
        rd_d      = rd_q;
        st_op_d   = st_op_q;
        wdata_d   = wdata_q;
        bmask_d   = bmask_q;
        wb_data_d = wb_data_q;
        exc_d     = exc_q;
        drop_d    = drop_q;
        cnt_d     = cnt_q;
        case (state_q)
            IDLE: begin
                cnt_d  = '0;
                drop_d = 1'b0;
                if (i_valid && !i_flush) begin
                    addr_d    = i_alu_data;
                    f3_d      = i_funct3;
                    rd_d      = i_rd_addr;
                    st_op_d   = i_lsu_wren;
                    wdata_d   = st_lanes;
                    bmask_d   = st_mask;
                    wb_data_d = '0;
                    exc_d     = 2'b00;
                    if (!is_mem) begin
                        wb_data_d = i_alu_data;
                        state_d   = RESP;
                    end else if (!f3_ok) begin
                        exc_d   = 2'b11;
                        state_d = RESP;
                    end else if (misal) begin
                        exc_d   = 2'b01;
                        state_d = RESP;
                    end else begin
                        state_d = REQ;
                    end
                end
            end
            REQ: begin
                // A grant coinciding with flush still commits the access.
                if (i_mem_gnt) begin
                    cnt_d = '0;
                    if (st_op_q) begin
                        state_d = i_flush ? IDLE : RESP;
                    end else begin
                        state_d = WAIT;
                        drop_d  = i_flush;
                    end
                end else if (i_flush) begin
                    state_d = IDLE;
                end
            end
            WAIT: begin
                if (i_flush) drop_d = 1'b1;
                if (i_mem_rvalid) begin
                    wb_data_d = ld_data;
                    state_d   = (drop_q || i_flush) ? IDLE : RESP;
                end else if (cnt_q == CW'(TIMEOUT - 1)) begin
                    wb_data_d = '0;
                    exc_d     = 2'b10;
                    state_d   = (drop_q || i_flush) ? IDLE : RESP;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            RESP: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            state_q   <= IDLE;
            addr_q    <= '0;
            f3_q      <= '0;
            rd_q      <= '0;
            st_op_q   <= 1'b0;
            wdata_q   <= '0;
            bmask_q   <= '0;
            wb_data_q <= '0;
            exc_q     <= '0;
            drop_q    <= 1'b0;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            f3_q      <= f3_d;
            rd_q      <= rd_d;
            st_op_q   <= st_op_d;
            wdata_q   <= wdata_d;
            bmask_q   <= bmask_d;
            wb_data_q <= wb_data_d;
            exc_q     <= exc_d;
            drop_q    <= drop_d;
            cnt_q     <= cnt_d;
        end
    end

    assign o_ready     = (state_q == IDLE);
    assign o_mem_req   = (state_q == REQ);
    assign o_mem_we    = (state_q == REQ) && st_op_q;
    assign o_mem_addr  = addr_q[31:2];
    assign o_mem_wdata = wdata_q;
    assign o_mem_bmask = bmask_q;
    assign o_wb_valid  = (state_q == RESP) && !i_flush;
    assign o_wb_data   = wb_data_q;
    assign o_wb_rd     = rd_q;
    assign o_exc       = exc_q;
endmodule

// File: tb/tb_mem_lsu.sv
// Directed bench for mem_lsu with a writeback scoreboard and a simple memory responder.
module tb_mem_lsu;
    logic        i_clk = 1'b0;
    logic        i_reset, i_valid, i_lsu_rden, i_lsu_wren, i_flush;
    logic [31:0] i_alu_data, i_st_data, i_mem_rdata;
    logic [2:0]  i_funct3;
    logic [4:0]  i_rd_addr;
    logic        o_ready, o_mem_req, o_mem_we, o_wb_valid;
    logic [29:0] o_mem_addr;
    logic [31:0] o_mem_wdata, o_wb_data;
    logic [3:0]  o_mem_bmask;
    logic [4:0]  o_wb_rd;
    logic [1:0]  o_exc;
    logic        i_mem_gnt, i_mem_rvalid;

    logic gnt_en = 1'b1, rv_en = 1'b1, rv_auto = 1'b0, rv_man = 1'b0, gr_seen = 1'b0;
    logic req_seen = 1'b0;

    typedef struct {
        logic [31:0] data;
        logic [4:0]  rd;
        logic [1:0]  exc;
        int          lat;
    } exp_t;
    exp_t sb[$];

    int checks = 0;
    int errors = 0;

    always #5 i_clk = ~i_clk;

    assign i_mem_gnt    = o_mem_req & gnt_en;
    assign i_mem_rvalid = rv_auto | rv_man;

    always @(negedge i_clk) begin
        gr_seen = o_mem_req & i_mem_gnt & ~o_mem_we;
        if (o_mem_req) req_seen = 1'b1;
    end
    always @(posedge i_clk) begin
        #1;
        rv_auto = gr_seen & rv_en;
    end

    mem_lsu #(.TIMEOUT(16)) dut (
        .i_clk(i_clk), .i_reset(i_reset), .i_valid(i_valid), .o_ready(o_ready),
        .i_alu_data(i_alu_data), .i_st_data(i_st_data), .i_lsu_rden(i_lsu_rden),
        .i_lsu_wren(i_lsu_wren), .i_funct3(i_funct3), .i_rd_addr(i_rd_addr),
        .i_flush(i_flush), .o_mem_req(o_mem_req), .o_mem_we(o_mem_we),
        .o_mem_addr(o_mem_addr), .o_mem_wdata(o_mem_wdata), .o_mem_bmask(o_mem_bmask),
        .i_mem_gnt(i_mem_gnt), .i_mem_rvalid(i_mem_rvalid), .i_mem_rdata(i_mem_rdata),
        .o_wb_valid(o_wb_valid), .o_wb_data(o_wb_data), .o_wb_rd(o_wb_rd), .o_exc(o_exc)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    task automatic push(input logic [31:0] data, input logic [4:0] rd, input logic [1:0] exc, input int lat);
        exp_t e;
        e.data = data; e.rd = rd; e.exc = exc; e.lat = lat;
        sb.push_back(e);
    endtask

    // Drives one entry; returns just after the accept edge.
    task automatic accept(input logic rd_en, input logic wr_en, input logic [2:0] f3,
                          input logic [31:0] addr, input logic [31:0] st, input logic [4:0] rd);
        @(posedge i_clk); #1;
        i_valid = 1'b1; i_lsu_rden = rd_en; i_lsu_wren = wr_en; i_funct3 = f3;
        i_alu_data = addr; i_st_data = st; i_rd_addr = rd;
        req_seen = 1'b0;
        @(posedge i_clk); #1;
        i_valid = 1'b0;
    endtask

    // Waits for the next writeback; 'done' windows after accept were already consumed.
    task automatic wait_wb(input string tag, input int done);
        exp_t e;
        bit   got;
        int   n;
        e   = sb.pop_front();
        got = 1'b0;
        n   = done;
        while (!got && n < 40) begin
            @(negedge i_clk);
            n++;
            if (o_wb_valid) begin
                got = 1'b1;
                chk({tag, " latency"}, n, e.lat);
                chk({tag, " data"}, o_wb_data, e.data);
                chk({tag, " rd"}, {27'd0, o_wb_rd}, {27'd0, e.rd});
                chk({tag, " exc"}, {30'd0, o_exc}, {30'd0, e.exc});
            end
        end
        if (!got) chk({tag, " wb_valid seen"}, 0, 1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1);
    end

    initial begin
        i_reset = 1'b0; i_valid = 1'b0; i_lsu_rden = 1'b0; i_lsu_wren = 1'b0; i_flush = 1'b0;
        i_alu_data = '0; i_st_data = '0; i_funct3 = '0; i_rd_addr = '0; i_mem_rdata = '0;
        repeat (3) @(posedge i_clk);
        @(negedge i_clk);
        chk("reset ready", o_ready, 1);
        chk("reset mem_req", o_mem_req, 0);
        chk("reset bmask", o_mem_bmask, 0);
        chk("reset wb_valid", o_wb_valid, 0);
        chk("reset exc", o_exc, 0);
        i_reset = 1'b1;

        // Non-memory pass-through
        push(32'hDEADBEEF, 5'd7, 2'b00, 1);
        accept(0, 0, 3'b000, 32'hDEADBEEF, 32'h0, 5'd7);
        wait_wb("nonmem", 0);

        // LB sign-extended byte 3
        i_mem_rdata = 32'h80FFFFFF;
        push(32'hFFFFFF80, 5'd3, 2'b00, 3);
        accept(1, 0, 3'b000, 32'h00001003, 32'h0, 5'd3);
        wait_wb("lb", 0);

        push(32'h00000080, 5'd4, 2'b00, 3);
        accept(1, 0, 3'b100, 32'h00001003, 32'h0, 5'd4);
        wait_wb("lbu", 0);

        i_mem_rdata = 32'h80FF1234;
        push(32'hFFFF80FF, 5'd5, 2'b00, 3);
        accept(1, 0, 3'b001, 32'h00001002, 32'h0, 5'd5);
        wait_wb("lh", 0);

        push(32'h000080FF, 5'd6, 2'b00, 3);
        accept(1, 0, 3'b101, 32'h00001002, 32'h0, 5'd6);
        wait_wb("lhu", 0);

        i_mem_rdata = 32'hCAFEF00D;
        push(32'hCAFEF00D, 5'd8, 2'b00, 3);
        accept(1, 0, 3'b010, 32'h00001004, 32'h0, 5'd8);
        wait_wb("lw", 0);

        // SH held in REQ for inspection, then granted
        gnt_en = 1'b0;
        push(32'h0, 5'd9, 2'b00, 3);
        accept(0, 1, 3'b001, 32'h00002002, 32'h0000ABCD, 5'd9);
        @(negedge i_clk);
        chk("sh req", o_mem_req, 1);
        chk("sh we", o_mem_we, 1);
        chk("sh bmask", o_mem_bmask, 4'b1100);
        chk("sh wdata", o_mem_wdata, 32'hABCDABCD);
        chk("sh addr", o_mem_addr, 30'h800);
        chk("sh ready", o_ready, 0);
        @(negedge i_clk);
        chk("sh req held", o_mem_req, 1);
        chk("sh bmask held", o_mem_bmask, 4'b1100);
        gnt_en = 1'b1;
        wait_wb("sh", 2);

        // SB with both enables set behaves as store
        gnt_en = 1'b0;
        push(32'h0, 5'd10, 2'b00, 2);
        accept(1, 1, 3'b000, 32'h00003001, 32'h12345677, 5'd10);
        @(negedge i_clk);
        chk("sb we", o_mem_we, 1);
        chk("sb bmask", o_mem_bmask, 4'b0010);
        chk("sb wdata", o_mem_wdata, 32'h77777777);
        gnt_en = 1'b1;
        wait_wb("sb", 1);

        // Misaligned and illegal funct3: no memory request
        push(32'h0, 5'd11, 2'b01, 1);
        accept(1, 0, 3'b010, 32'h00001001, 32'h0, 5'd11);
        wait_wb("lw misaligned", 0);
        chk("lw misaligned no req", req_seen, 0);

        push(32'h0, 5'd12, 2'b11, 1);
        accept(1, 0, 3'b011, 32'h00001000, 32'h0, 5'd12);
        wait_wb("load illegal f3", 0);
        push(32'h0, 5'd13, 2'b11, 1);
        accept(0, 1, 3'b100, 32'h00001000, 32'h0, 5'd13);
        wait_wb("store illegal f3", 0);
        chk("illegal no req", req_seen, 0);

        // LHU timeout: 1 REQ + 16 WAIT windows, response in window 18
        rv_en = 1'b0;
        push(32'h0, 5'd14, 2'b10, 18);
        accept(1, 0, 3'b101, 32'h00001002, 32'h0, 5'd14);
        wait_wb("lhu timeout", 0);

        // Flush while waiting, then late rvalid: entry dropped
        accept(1, 0, 3'b010, 32'h00003000, 32'h0, 5'd15);
        @(negedge i_clk);
        chk("flush granted", o_mem_req, 1);
        @(posedge i_clk); #1;
        i_flush = 1'b1;
        @(negedge i_clk);
        chk("flush wait wb", o_wb_valid, 0);
        @(posedge i_clk); #1;
        i_flush = 1'b0; rv_man = 1'b1;
        @(negedge i_clk);
        chk("flush still waiting", o_ready, 0);
        @(posedge i_clk); #1;
        rv_man = 1'b0;
        @(negedge i_clk);
        chk("flush ready back", o_ready, 1);
        chk("flush no wb", o_wb_valid, 0);
        rv_en = 1'b1;

        // Flush with valid in IDLE: nothing accepted
        @(posedge i_clk); #1;
        i_valid = 1'b1; i_lsu_rden = 1'b0; i_lsu_wren = 1'b0; i_flush = 1'b1; i_alu_data = 32'h55;
        @(posedge i_clk); #1;
        i_valid = 1'b0; i_flush = 1'b0;
        @(negedge i_clk);
        chk("idle flush no wb", o_wb_valid, 0);
        chk("idle flush ready", o_ready, 1);

        // Asynchronous reset while in REQ
        gnt_en = 1'b0;
        accept(1, 0, 3'b010, 32'h00004000, 32'h0, 5'd16);
        @(negedge i_clk);
        chk("rst pre req", o_mem_req, 1);
        #2 i_reset = 1'b0;
        #1;
        chk("rst async req", o_mem_req, 0);
        chk("rst async ready", o_ready, 1);
        chk("rst async addr", o_mem_addr, 0);
        chk("rst async rd", o_wb_rd, 0);
        @(negedge i_clk);
        i_reset = 1'b1;
        gnt_en = 1'b1;
        @(negedge i_clk);
        chk("rst after no wb", o_wb_valid, 0);
        chk("rst after ready", o_ready, 1);
        chk("scoreboard drained", sb.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
